// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer: splits word/half/byte accesses into little-endian byte transfers.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of executing them.
module lsu_byte_seq #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    localparam logic [2:0] TY_W  = 3'b000;
    localparam logic [2:0] TY_H  = 3'b001;
    localparam logic [2:0] TY_HU = 3'b010;
    localparam logic [2:0] TY_B  = 3'b011;
    localparam logic [2:0] TY_BU = 3'b100;

    typedef enum logic [1:0] {IDLE, XFER, RTAIL, RESP} state_t;

    state_t              state_q;
    logic                we_q;
    logic [2:0]          type_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [2:0]          n_q;
    logic [2:0]          cnt_q;
    logic [31:0]         data_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [31:0]         resp_rdata_q;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [7:0]          mem_wdata_q;

    logic [2:0]          cnt_d;
    logic [1:0]          nxt_idx;
    logic [1:0]          cap_idx;
    logic [31:0]         asm_d;
    logic [31:0]         ext_d;
    logic                req_err;
    logic [2:0]          req_n;

    always_comb begin
        cnt_d   = cnt_q + 3'd1;
        nxt_idx = cnt_d[1:0];
        // Read data lags the address by one cycle, so it belongs to the previous byte.
        cap_idx = cnt_q[1:0] - 2'd1;
        asm_d   = data_q;
        asm_d[{cap_idx, 3'b000} +: 8] = mem_rdata;
        case (type_q)
            TY_W:    ext_d = asm_d;
            TY_H:    ext_d = {{16{asm_d[15]}}, asm_d[15:0]};
            TY_HU:   ext_d = {16'h0000, asm_d[15:0]};
            TY_B:    ext_d = {{24{asm_d[7]}}, asm_d[7:0]};
            TY_BU:   ext_d = {24'h000000, asm_d[7:0]};
            default: ext_d = '0;
        endcase
    end

    always_comb begin
        req_err = (req_type > TY_BU);
`ifdef LSU_MISALIGN_TRAP_EN
        if (((req_type == TY_H) || (req_type == TY_HU)) && req_addr[0])
            req_err = 1'b1;
        if ((req_type == TY_W) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`endif
        case (req_type)
            TY_W:        req_n = 3'd4;
            TY_H, TY_HU: req_n = 3'd2;
            default:     req_n = 3'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            type_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            n_q          <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        type_q  <= req_type;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        n_q     <= req_n;
                        cnt_q   <= '0;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            // First byte is presented straight from the request to keep outputs registered.
                            state_q     <= XFER;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= req_we;
                            mem_addr_q  <= req_addr;
                            mem_wdata_q <= req_wdata[7:0];
                        end
                    end
                end
                XFER: begin
                    cnt_q <= cnt_d;
                    if (!we_q && (cnt_q != 3'd0))
                        data_q <= asm_d;
                    if (cnt_d == n_q) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        if (we_q) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q <= RTAIL;
                        end
                    end else begin
                        mem_addr_q  <= addr_q + ADDR_W'(cnt_d);
                        mem_wdata_q <= wdata_q[{nxt_idx, 3'b000} +: 8];
                    end
                end
                RTAIL: begin
                    data_q       <= asm_d;
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= ext_d;
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Scoreboard bench for lsu_byte_seq: model-predicted memory transfers and responses, checked by a monitor.
module tb_lsu_byte_seq;

    localparam int unsigned AW  = 6;
    localparam int unsigned MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_type = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    lsu_byte_seq #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [31:0]   cyc;
    } mem_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] cyc;
    } resp_t;

    mem_t  exp_mem[$];
    resp_t exp_resp[$];

    int unsigned nchk = 0;
    int unsigned nfail = 0;

    // Physical byte memory seen by the DUT, and the bench's own view of its contents.
    logic [7:0] mem [MSZ];
    logic [7:0] ref_mem [MSZ];
    logic       filled = 1'b0;

    function automatic logic [7:0] init_byte(input int unsigned i);
        return 8'((i * 37 + 11) & 32'hFF);
    endfunction

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= init_byte(i);
            filled <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    mem_t  mon_m;
    resp_t mon_r;

    always @(negedge clk) begin
        if (rstn) begin
            if (mem_en) begin
                if (exp_mem.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL mem_unexpected actual=en addr=%0d required=idle (cycle %0d)", mem_addr, cyc);
                end else begin
                    mon_m = exp_mem.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(mon_m.we));
                    chk("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
                    if (mon_m.we) chk("mem_wdata", 32'(mem_wdata), 32'(mon_m.data));
                    chk("mem_cycle", cyc, mon_m.cyc);
                end
            end
            if (resp_valid) begin
                if (exp_resp.size() == 0) begin
                    nchk++; nfail++;
                    $display("FAIL resp_unexpected actual=valid required=none (cycle %0d)", cyc);
                end else begin
                    mon_r = exp_resp.pop_front();
                    chk("resp_rdata", resp_rdata, mon_r.rdata);
                    chk("resp_err", 32'(resp_err), 32'(mon_r.err));
                    chk("resp_cycle", cyc, mon_r.cyc);
                end
            end
        end
    end

    // Reference: bytes at (addr+k) mod 2^AW, little-endian, extended by arithmetic on the value.
    task automatic model(input logic we, input logic [2:0] ty, input logic [AW-1:0] a,
                         input logic [31:0] wd, input int unsigned acc);
        int unsigned n, w;
        logic        err;
        logic [7:0]  b;
        logic [31:0] val;
        err = (ty > 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        if (((ty == 3'd1) || (ty == 3'd2)) && (a % 2 != 0)) err = 1'b1;
        if ((ty == 3'd0) && (a % 4 != 0)) err = 1'b1;
`endif
        if (err) begin
            exp_resp.push_back('{rdata: 32'h0, err: 1'b1, cyc: acc + 1});
            return;
        end
        n = (ty == 3'd0) ? 4 : ((ty <= 3'd2) ? 2 : 1);
        val = 32'h0;
        for (int k = 0; k < n; k++) begin
            w = (int'(a) + k) % MSZ;
            if (we) begin
                b = 8'((wd >> (8 * k)) & 32'hFF);
                ref_mem[w] = b;
                exp_mem.push_back('{we: 1'b1, addr: AW'(w), data: b, cyc: acc + 1 + k});
            end else begin
                val = val + (32'(ref_mem[w]) << (8 * k));
                exp_mem.push_back('{we: 1'b0, addr: AW'(w), data: 8'h00, cyc: acc + 1 + k});
            end
        end
        if (we) begin
            exp_resp.push_back('{rdata: 32'h0, err: 1'b0, cyc: acc + n + 1});
        end else begin
            if ((ty == 3'd1) && (val >= 32'h8000)) val = val + 32'hFFFF0000;
            if ((ty == 3'd3) && (val >= 32'h80))   val = val + 32'hFFFFFF00;
            exp_resp.push_back('{rdata: val, err: 1'b0, cyc: acc + n + 2});
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] ty, input logic [AW-1:0] a, input logic [31:0] wd);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = we; req_type = ty; req_addr = a; req_wdata = wd;
            if (req_ready) got = 1'b1;
        end
        if (!got) begin
            nchk++; nfail++;
            $display("FAIL accept_timeout actual=not_ready required=ready (cycle %0d)", cyc);
            req_valid = 1'b0;
            return;
        end
        model(we, ty, a, wd, cyc);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_type  = 3'($urandom_range(0, 7));
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200 && (exp_resp.size() != 0 || exp_mem.size() != 0); t++) @(negedge clk);
        @(negedge clk);
        chk("drain_resp_queue", 32'(exp_resp.size()), 32'h0);
        chk("idle_ready", 32'(req_ready), 32'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        chk({tag, "_resp_err"},   32'(resp_err),   32'h0);
        chk({tag, "_resp_rdata"}, resp_rdata,      32'h0);
        chk({tag, "_mem_en"},     32'(mem_en),     32'h0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'h0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
        chk({tag, "_mem_wdata"},  32'(mem_wdata),  32'h0);
        chk({tag, "_req_ready"},  32'(req_ready),  32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ty;
        for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;

        issue(1'b1, 3'd0, AW'(4),  32'hDEADBEEF);
        issue(1'b0, 3'd0, AW'(4),  32'h0);
        issue(1'b1, 3'd3, AW'(9),  32'h00000080);
        issue(1'b0, 3'd3, AW'(9),  32'h0);
        issue(1'b0, 3'd4, AW'(9),  32'h0);
        issue(1'b1, 3'd3, AW'(8),  32'h00000001);
        issue(1'b0, 3'd1, AW'(8),  32'h0);
        issue(1'b1, 3'd0, AW'(62), 32'h11223344);
        issue(1'b0, 3'd0, AW'(62), 32'h0);
        issue(1'b0, 3'd6, AW'(5),  32'h0);
        issue(1'b1, 3'd7, AW'(0),  32'hFFFFFFFF);
        issue(1'b0, 3'd1, AW'(3),  32'h0);
        issue(1'b0, 3'd2, AW'(63), 32'h0);
        issue(1'b1, 3'd1, AW'(63), 32'h0000A55A);
        issue(1'b0, 3'd1, AW'(63), 32'h0);
        wait_idle();

        // Reset during the second byte of a word store at address 0.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_type = 3'd0; req_addr = '0; req_wdata = 32'hA1B2C3D4;
        chk("abort_accept_ready", 32'(req_ready), 32'h1);
        exp_mem.push_back('{we: 1'b1, addr: AW'(0), data: 8'hD4, cyc: cyc + 1});
        ref_mem[0] = 8'hD4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'h0);
        end
        chk("abort_pending_bytes", 32'(exp_mem.size()), 32'h0);
        rstn = 1'b1;
        issue(1'b0, 3'd0, AW'(0), 32'h0);
        issue(1'b0, 3'd4, AW'(1), 32'h0);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 7) == 0) ty = 3'($urandom_range(5, 7));
            else                           ty = 3'($urandom_range(0, 4));
            issue(1'($urandom_range(0, 1)), ty, AW'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();
        chk("drain_mem_queue", 32'(exp_mem.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/lsu_byte_seq.md
# lsu_byte_seq

Load/store sequencer between the execute stage and a byte-wide data memory port. It accepts one load or store per request, splits it into 1, 2 or 4 little-endian byte transfers on the memory port, and assembles load results with sign or zero extension. It returns a one-cycle response with data or an error flag.

## Interface
Parameters:
- ADDR_W, default 6: byte address width of the memory port. Addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_type  in  3  access type:
  - 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned
  - 101–111 illegal
- req_addr  in  ADDR_W  byte address of the least-significant byte
- req_wdata  in  32  store data; bits [8k+7:8k] go to address addr+k
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal type or trapped misalignment; valid with resp_valid
- mem_en  out  1  byte transfer this cycle
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, valid the cycle after a read mem_en (synchronous read)

## Operation
- States: IDLE, XFER, RTAIL, RESP.
- IDLE: req_ready=1. On acceptance:
  - Latch we, type, addr, wdata. Clear the byte counter cnt.
  - Set N = 4 for word, 2 for half, 1 for byte.
  - Illegal type goes to RESP with err=1. Otherwise go to XFER.
- XFER: mem_en=1, mem_we=we, mem_addr=(addr+cnt) mod 2^ADDR_W, mem_wdata=wdata byte cnt. Increment cnt.
  - After issuing byte N-1: stores go to RESP, loads go to RTAIL.
- Load capture: from the second XFER cycle onward and in RTAIL, mem_rdata is stored into assembly byte (cnt-1).
- RTAIL: mem_en=0. Capture the final byte, then go to RESP.
- RESP: resp_valid=1, resp_err=err, resp_rdata set as follows, then go to IDLE.
  - word: {b3,b2,b1,b0}
  - half: {16{b1[7]}},b1,b0. Half unsigned zero-extends.
  - byte: {24{b0[7]}},b0. Byte unsigned zero-extends.
- Outputs are registered or decoded from state only. There is no combinational path from req_* or mem_rdata to any output.
- req_ready is 0 in XFER, RTAIL and RESP. There is no request queueing.
- Address wrap: a word at addr 2^ADDR_W-2 touches 62, 63, 0, 1 when ADDR_W=6.
- Reset values: state IDLE, req_ready 1 once rstn deasserts, resp_valid 0, resp_err 0, resp_rdata 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, cnt 0.
- Reset asserted mid-operation aborts immediately with mem_en=0. Bytes already written stay written, with no rollback. No response is produced.

## Timing
- Acceptance cycle is cycle 0.
- Store of N bytes: mem_en in cycles 1..N, resp_valid in cycle N+1.
- Load of N bytes: mem_en in cycles 1..N, RTAIL in cycle N+1, resp_valid in cycle N+2.
- Error: resp_valid in cycle 1, no mem_en.
- Next acceptance is earliest in the cycle after RESP. Word store throughput is one request per 6 cycles.
- mem_en is continuous within one request. No idle cycles between byte transfers.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Half with addr[0]=1 or word with addr[1:0]≠0 goes directly to RESP with resp_err=1 and resp_rdata=0.
  - No memory access occurs. Timing is the same as an illegal type.
- Undefined: misaligned accesses proceed bytewise like aligned ones, and resp_err is only for illegal type.

## Test plan
- Word store 0xDEADBEEF at addr 4, then word load at 4:
  - mem writes EF,BE,AD,DE to addrs 4..7 in cycles 1..4, store resp in cycle 5.
  - Load returns 0xDEADBEEF in cycle 6, resp_err=0.
- Byte store 0x80 at addr 9:
  - Byte load gives 0xFFFFFF80. Byte unsigned gives 0x00000080.
  - Half load at 8 with byte 8 = 0x01 gives 0xFFFF8001.
- Word store 0x11223344 at addr 62 (ADDR_W=6):
  - Writes to addrs 62, 63, 0, 1 with bytes 44, 33, 22, 11.
  - Load at 62 returns 0x11223344, without the macro.
- req_type=110:
  - resp_valid with resp_err=1 in cycle 1, mem_en never high, resp_rdata=0.
- With LSU_MISALIGN_TRAP_EN, half load at addr 3:
  - resp_err=1 in cycle 1, no mem_en.
  - Without the macro, the same request reads addrs 3, 4 and responds in cycle 4.
- rstn low in cycle 2 of a word store at addr 0:
  - Only byte 0 (and byte 1 if the edge has passed) is written. All outputs are at reset values, no resp_valid.
  - The next request is accepted normally.
